instruction_fetcher: RTL and testbench
======================================

Name: instruction_fetcher

Overview:
- Per-core producer of the 16-bit instruction word consumed by the decode stage.
- Drives a valid/ready read request to program memory at the current PC during the core's FETCH state, then holds the returned word stable through DECODE.
- A single-entry, PC-tagged instruction buffer lets tight loops and branch-to-self skip the memory round trip.
- Reports progress to the core scheduler through fetcher_state.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, width of PC and program-memory address.
- PROGRAM_MEM_DATA_BITS, 16, instruction word width.
- BUFFER_ENABLE, 1, 1 = single-entry PC-tagged buffer present; 0 = every fetch goes to memory.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- core_state  input  3  core scheduler state: 000 IDLE, 001 FETCH, 010 DECODE, 011 REQUEST, 100 WAIT, 101 EXECUTE, 110 UPDATE, 111 DONE
- current_pc  input  PROGRAM_MEM_ADDR_BITS  address of the instruction to fetch
- flush  input  1  invalidate the buffer (kernel launch / program reload)
- mem_read_valid  output  1  read request to program memory
- mem_read_address  output  PROGRAM_MEM_ADDR_BITS  request address
- mem_read_ready  input  1  memory response strobe; data valid this cycle
- mem_read_data  input  PROGRAM_MEM_DATA_BITS  returned instruction
- fetcher_state  output  3  000 IDLE, 001 FETCHING, 010 FETCHED
- instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction word
- buf_hit  output  1  one-cycle pulse when a fetch is served from the buffer

Behaviour:
- Reset, checked first in the same always block:
  - fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, buf_hit=0.
  - buffer valid=0, tag=0, data=0.
- All outputs are registered; buf_hit defaults to 0 every cycle unless set below.
- IDLE, core_state==FETCH:
  - Hit (BUFFER_ENABLE=1, buffer valid, tag==current_pc): instruction<=buffer data, buf_hit<=1, next FETCHED, no memory request.
  - Miss: mem_read_valid<=1, mem_read_address<=current_pc, next FETCHING.
- IDLE, core_state != FETCH: hold all outputs.
- FETCHING:
  - mem_read_valid and mem_read_address are held constant until mem_read_ready==1.
  - On the ready cycle: instruction<=mem_read_data, mem_read_valid<=0, next FETCHED.
  - On the same cycle, if BUFFER_ENABLE: buffer data<=mem_read_data, tag<=mem_read_address, valid<=1.
  - Zero-wait memory (ready in the first FETCHING cycle) is legal.
- FETCHED:
  - instruction held stable.
  - When core_state==DECODE, next IDLE.
  - instruction remains unchanged until the next fetch completes, so the decoder samples a stable word throughout DECODE.
- Latency from entering FETCH to fetcher_state==FETCHED:
  - Hit: 1 cycle.
  - Miss: 1 cycle to issue the request, plus the wait cycles until ready, plus 1 cycle to capture.
- mem_read_ready outside FETCHING is ignored; no state or data change.
- flush:
  - Clears buffer valid on the next edge, in any state.
  - If flush coincides with a buffer fill, flush wins and the buffer ends invalid; instruction is still captured normally.
  - If flush coincides with a hit check in IDLE, it is treated as a miss.
- current_pc changes while FETCHING do not alter the in-flight address.
- Reset mid-fetch drops the request immediately (valid=0 on the next edge). A late ready from memory is then ignored because the block is in IDLE.
- BUFFER_ENABLE=0: buf_hit is constantly 0 and the buffer registers are absent.
- No combinational path from any input to any output.

Test Plan:
- Cold miss: reset, current_pc=0x05, core_state=FETCH, ready asserted 3 cycles after valid with data 0x3123 -> mem_read_valid=1 / address 0x05 held for exactly 3 cycles; then instruction=0x3123, fetcher_state=010, buf_hit=0.
- Buffer hit: repeat the fetch at pc=0x05 after DECODE -> FETCHED one cycle after FETCH, buf_hit pulses 1 for one cycle, mem_read_valid never asserts, instruction=0x3123.
- Tag mismatch: buffer holds pc 0x05, fetch pc=0x06 with memory data 0x9A07 -> request issued to 0x06, instruction=0x9A07; a later fetch at 0x05 misses (buffer now tagged 0x06).
- Flush collision: flush asserted on the same cycle as ready (data 0xF000) -> instruction=0xF000, buffer invalid; the next fetch at the same pc issues a memory request.
- Reset mid-fetch: reset asserted during FETCHING, ready pulses one cycle after reset deasserts -> all outputs 0, fetcher_state=IDLE, ready ignored, instruction stays 0x0000.
- Zero-wait memory plus PC change: ready high in the first FETCHING cycle while current_pc is changed during FETCHING -> capture uses the original address; FETCHED is reached 2 cycles after FETCH.

Source files
------------

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: fetches the 16-bit instruction word at current_pc during
// the core's FETCH state. It issues a valid/ready read to program memory and then
// holds the returned word stable through DECODE. An optional single-entry buffer,
// tagged with the PC, serves repeated fetches of the same PC without a memory read.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   core_state         core scheduler state (FETCH=001, DECODE=010)
//   current_pc         address of the instruction to fetch
//   flush              invalidate the buffer
//   mem_read_valid     read request to program memory (registered)
//   mem_read_address   request address (registered)
//   mem_read_ready     memory response strobe
//   mem_read_data      returned instruction word
//   fetcher_state      000 IDLE, 001 FETCHING, 010 FETCHED (registered)
//   instruction        fetched instruction word (registered)
//   buf_hit            one-cycle pulse when a fetch is served by the buffer
module instruction_fetcher #(
   parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
   parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
   parameter bit          BUFFER_ENABLE         = 1'b1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [2:0]                       core_state,
   input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
   input  logic                             flush,
   output logic                             mem_read_valid,
   output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
   input  logic                             mem_read_ready,
   input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
   output logic [2:0]                       fetcher_state,
   output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
   output logic                             buf_hit
);

   localparam int unsigned AW = PROGRAM_MEM_ADDR_BITS;
   localparam int unsigned DW = PROGRAM_MEM_DATA_BITS;

   localparam logic [2:0] CORE_FETCH  = 3'b001;
   localparam logic [2:0] CORE_DECODE = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE     = 3'b000,
      S_FETCHING = 3'b001,
      S_FETCHED  = 3'b010
   } state_t;

   state_t          state, state_n;
   logic            valid_n;
   logic [AW-1:0]   addr_n;
   logic [DW-1:0]   instr_n;
   logic            hit_n;

   logic            buf_valid, buf_valid_n;
   logic [AW-1:0]   buf_tag,   buf_tag_n;
   logic [DW-1:0]   buf_data,  buf_data_n;

   assign fetcher_state = state;

   // Main state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         mem_read_valid   <= 1'b0;
         mem_read_address <= '0;
         instruction      <= '0;
         buf_hit          <= 1'b0;
      end else begin
         state            <= state_n;
         mem_read_valid   <= valid_n;
         mem_read_address <= addr_n;
         instruction      <= instr_n;
         buf_hit          <= hit_n;
      end
   end

   // Buffer registers exist only when the buffer is enabled
   if (BUFFER_ENABLE) begin : g_buf
      always_ff @(posedge clk) begin
         if (reset) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
         end else begin
            buf_valid <= buf_valid_n;
            buf_tag   <= buf_tag_n;
            buf_data  <= buf_data_n;
         end
      end
   end else begin : g_nobuf
      assign buf_valid = 1'b0;
      assign buf_tag   = '0;
      assign buf_data  = '0;
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      valid_n     = mem_read_valid;
      addr_n      = mem_read_address;
      instr_n     = instruction;
      hit_n       = 1'b0;
      buf_valid_n = buf_valid;
      buf_tag_n   = buf_tag;
      buf_data_n  = buf_data;

      unique case (state)
         S_IDLE: begin
            if (core_state == CORE_FETCH) begin
               // A flush in the same cycle forces a miss
               if (BUFFER_ENABLE && buf_valid && !flush && (buf_tag == current_pc)) begin
                  instr_n = buf_data;
                  hit_n   = 1'b1;
                  state_n = S_FETCHED;
               end else begin
                  valid_n = 1'b1;
                  addr_n  = current_pc;
                  state_n = S_FETCHING;
               end
            end
         end
         S_FETCHING: begin
            if (mem_read_ready) begin
               instr_n = mem_read_data;
               valid_n = 1'b0;
               state_n = S_FETCHED;
               if (BUFFER_ENABLE) begin
                  // Tag with the in-flight address, not the live PC
                  buf_data_n  = mem_read_data;
                  buf_tag_n   = mem_read_address;
                  buf_valid_n = 1'b1;
               end
            end
         end
         S_FETCHED: begin
            if (core_state == CORE_DECODE) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

      // Flush overrides any fill happening in the same cycle
      if (flush) buf_valid_n = 1'b0;
   end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed self-checking bench for instruction_fetcher. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_instruction_fetcher;

   logic        clk;
   logic        reset;
   logic [2:0]  core_state;
   logic [7:0]  current_pc;
   logic        flush;
   logic        mem_read_valid;
   logic [7:0]  mem_read_address;
   logic        mem_read_ready;
   logic [15:0] mem_read_data;
   logic [2:0]  fetcher_state;
   logic [15:0] instruction;
   logic        buf_hit;

   int errors = 0;
   int checks = 0;

   localparam logic [2:0] C_IDLE   = 3'b000;
   localparam logic [2:0] C_FETCH  = 3'b001;
   localparam logic [2:0] C_DECODE = 3'b010;

   instruction_fetcher dut (
      .clk              (clk),
      .reset            (reset),
      .core_state       (core_state),
      .current_pc       (current_pc),
      .flush            (flush),
      .mem_read_valid   (mem_read_valid),
      .mem_read_address (mem_read_address),
      .mem_read_ready   (mem_read_ready),
      .mem_read_data    (mem_read_data),
      .fetcher_state    (fetcher_state),
      .instruction      (instruction),
      .buf_hit          (buf_hit)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      step();
      checks++; if (fetcher_state !== 3'b000) begin errors++; $display("FAIL reset_state: got %b want 000", fetcher_state); end
      checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mem_read_valid); end
      checks++; if (mem_read_address !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", mem_read_address); end
      checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", instruction); end
      checks++; if (buf_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", buf_hit); end
      reset = 1'b0;
      step();
      checks++; if (fetcher_state !== 3'b000) begin errors++; $display("FAIL idle_hold_state: got %b want 000", fetcher_state); end
   endtask

   task automatic test_cold_miss();
      core_state = C_FETCH; current_pc = 8'h05;
      step();
      for (int i = 0; i < 3; i++) begin
         checks++; if (mem_read_valid !== 1'b1) begin errors++; $display("FAIL cold_valid[%0d]: got %b want 1", i, mem_read_valid); end
         checks++; if (mem_read_address !== 8'h05) begin errors++; $display("FAIL cold_addr[%0d]: got %h want 05", i, mem_read_address); end
         checks++; if (fetcher_state !== 3'b001) begin errors++; $display("FAIL cold_fetching[%0d]: got %b want 001", i, fetcher_state); end
         if (i == 2) begin mem_read_ready = 1'b1; mem_read_data = 16'h3123; end
         step();
      end
      mem_read_ready = 1'b0; mem_read_data = 16'h0000;
      checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL cold_valid_drop: got %b want 0", mem_read_valid); end
      checks++; if (instruction !== 16'h3123) begin errors++; $display("FAIL cold_instr: got %h want 3123", instruction); end
      checks++; if (fetcher_state !== 3'b010) begin errors++; $display("FAIL cold_fetched: got %b want 010", fetcher_state); end
      checks++; if (buf_hit !== 1'b0) begin errors++; $display("FAIL cold_hit: got %b want 0", buf_hit); end
      step();
      checks++; if (fetcher_state !== 3'b010) begin errors++; $display("FAIL fetched_hold: got %b want 010", fetcher_state); end
   endtask

   task automatic test_buffer_hit();
      core_state = C_DECODE;
      step();
      checks++; if (fetcher_state !== 3'b000) begin errors++; $display("FAIL decode_to_idle: got %b want 000", fetcher_state); end
      checks++; if (instruction !== 16'h3123) begin errors++; $display("FAIL decode_instr_stable: got %h want 3123", instruction); end
      core_state = C_FETCH; current_pc = 8'h05;
      step();
      checks++; if (fetcher_state !== 3'b010) begin errors++; $display("FAIL hit_fetched: got %b want 010", fetcher_state); end
      checks++; if (buf_hit !== 1'b1) begin errors++; $display("FAIL hit_pulse: got %b want 1", buf_hit); end
      checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL hit_no_req: got %b want 0", mem_read_valid); end
      checks++; if (instruction !== 16'h3123) begin errors++; $display("FAIL hit_instr: got %h want 3123", instruction); end
      core_state = C_DECODE;
      step();
      checks++; if (buf_hit !== 1'b0) begin errors++; $display("FAIL hit_pulse_end: got %b want 0", buf_hit); end
      checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL hit_no_req2: got %b want 0", mem_read_valid); end
   endtask

   task automatic test_tag_mismatch();
      core_state = C_FETCH; current_pc = 8'h06;
      step();
      checks++; if (mem_read_valid !== 1'b1) begin errors++; $display("FAIL tag_valid: got %b want 1", mem_read_valid); end
      checks++; if (mem_read_address !== 8'h06) begin errors++; $display("FAIL tag_addr: got %h want 06", mem_read_address); end
      checks++; if (buf_hit !== 1'b0) begin errors++; $display("FAIL tag_hit: got %b want 0", buf_hit); end
      mem_read_ready = 1'b1; mem_read_data = 16'h9A07;
      step();
      checks++; if (instruction !== 16'h9A07) begin errors++; $display("FAIL tag_instr: got %h want 9a07", instruction); end
      mem_read_ready = 1'b0; core_state = C_DECODE;
      step();
      core_state = C_FETCH; current_pc = 8'h05;
      step();
      checks++; if (mem_read_valid !== 1'b1) begin errors++; $display("FAIL retag_valid: got %b want 1", mem_read_valid); end
      checks++; if (mem_read_address !== 8'h05) begin errors++; $display("FAIL retag_addr: got %h want 05", mem_read_address); end
      checks++; if (buf_hit !== 1'b0) begin errors++; $display("FAIL retag_hit: got %b want 0", buf_hit); end
      mem_read_ready = 1'b1; mem_read_data = 16'h3123;
      step();
      checks++; if (instruction !== 16'h3123) begin errors++; $display("FAIL retag_instr: got %h want 3123", instruction); end
      mem_read_ready = 1'b0; core_state = C_DECODE;
      step();
   endtask

   task automatic test_flush();
      core_state = C_FETCH; current_pc = 8'h10;
      step();
      checks++; if (mem_read_valid !== 1'b1) begin errors++; $display("FAIL flush_req: got %b want 1", mem_read_valid); end
      mem_read_ready = 1'b1; mem_read_data = 16'hF000; flush = 1'b1;
      step();
      checks++; if (instruction !== 16'hF000) begin errors++; $display("FAIL flush_instr: got %h want f000", instruction); end
      checks++; if (fetcher_state !== 3'b010) begin errors++; $display("FAIL flush_fetched: got %b want 010", fetcher_state); end
      mem_read_ready = 1'b0; flush = 1'b0; core_state = C_DECODE;
      step();
      core_state = C_FETCH; current_pc = 8'h10;
      step();
      checks++; if (mem_read_valid !== 1'b1) begin errors++; $display("FAIL flush_refetch_valid: got %b want 1", mem_read_valid); end
      checks++; if (buf_hit !== 1'b0) begin errors++; $display("FAIL flush_refetch_hit: got %b want 0", buf_hit); end
      mem_read_ready = 1'b1; mem_read_data = 16'h1111;
      step();
      mem_read_ready = 1'b0; core_state = C_DECODE;
      step();
      // buffer now valid for 0x10; a flush during the hit check forces a miss
      core_state = C_FETCH; current_pc = 8'h10; flush = 1'b1;
      step();
      flush = 1'b0;
      checks++; if (mem_read_valid !== 1'b1) begin errors++; $display("FAIL flush_hitchk_valid: got %b want 1", mem_read_valid); end
      checks++; if (fetcher_state !== 3'b001) begin errors++; $display("FAIL flush_hitchk_state: got %b want 001", fetcher_state); end
      mem_read_ready = 1'b1; mem_read_data = 16'h2222;
      step();
      checks++; if (instruction !== 16'h2222) begin errors++; $display("FAIL flush_hitchk_instr: got %h want 2222", instruction); end
      mem_read_ready = 1'b0; core_state = C_DECODE;
      step();
   endtask

   task automatic test_reset_mid_fetch();
      core_state = C_FETCH; current_pc = 8'h20;
      step();
      checks++; if (mem_read_valid !== 1'b1) begin errors++; $display("FAIL rmid_req: got %b want 1", mem_read_valid); end
      reset = 1'b1;
      step();
      checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", mem_read_valid); end
      checks++; if (fetcher_state !== 3'b000) begin errors++; $display("FAIL rmid_state: got %b want 000", fetcher_state); end
      checks++; if (mem_read_address !== 8'h00) begin errors++; $display("FAIL rmid_addr: got %h want 00", mem_read_address); end
      checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL rmid_instr: got %h want 0000", instruction); end
      reset = 1'b0; core_state = C_IDLE;
      step();
      mem_read_ready = 1'b1; mem_read_data = 16'hDEAD;
      step();
      mem_read_ready = 1'b0;
      checks++; if (fetcher_state !== 3'b000) begin errors++; $display("FAIL late_ready_state: got %b want 000", fetcher_state); end
      checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL late_ready_instr: got %h want 0000", instruction); end
      checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL late_ready_valid: got %b want 0", mem_read_valid); end
      step();
   endtask

   task automatic test_zero_wait_pc_change();
      core_state = C_FETCH; current_pc = 8'h10;
      step();
      // buffer was cleared by reset, so 0x10 must miss
      checks++; if (mem_read_valid !== 1'b1) begin errors++; $display("FAIL zw_valid: got %b want 1", mem_read_valid); end
      checks++; if (mem_read_address !== 8'h10) begin errors++; $display("FAIL zw_addr: got %h want 10", mem_read_address); end
      current_pc = 8'h44; mem_read_ready = 1'b1; mem_read_data = 16'h5A5A;
      step();
      checks++; if (fetcher_state !== 3'b010) begin errors++; $display("FAIL zw_fetched: got %b want 010", fetcher_state); end
      checks++; if (instruction !== 16'h5A5A) begin errors++; $display("FAIL zw_instr: got %h want 5a5a", instruction); end
      mem_read_ready = 1'b0; core_state = C_DECODE;
      step();
      core_state = C_FETCH; current_pc = 8'h10;
      step();
      checks++; if (buf_hit !== 1'b1) begin errors++; $display("FAIL zw_tag_hit: got %b want 1", buf_hit); end
      checks++; if (instruction !== 16'h5A5A) begin errors++; $display("FAIL zw_tag_instr: got %h want 5a5a", instruction); end
      checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL zw_tag_no_req: got %b want 0", mem_read_valid); end
      core_state = C_DECODE;
      step();
   endtask

   initial begin
      reset          = 1'b1;
      core_state     = C_IDLE;
      current_pc     = 8'h00;
      flush          = 1'b0;
      mem_read_ready = 1'b0;
      mem_read_data  = 16'h0000;
      step();
      test_reset();
      test_cold_miss();
      test_buffer_hit();
      test_tag_mismatch();
      test_flush();
      test_reset_mid_fetch();
      test_zero_wait_pc_change();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
